// File: rtl/cheetah_pipe_pkg.sv
// Shared types for the pipeline register slice: control word layout,
// bubble instruction and forwarding-select encoding.
package cheetah_pipe_pkg;

    typedef struct packed {
        logic       reg_wr;
        logic [1:0] wb_sel;
        logic       mem_wr;
        logic [2:0] br_type;
        logic [3:0] alu_op;
        logic       sel_A;
        logic       sel_B;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // addi x0,x0,0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FWD_M  = 2'b00,
        FWD_RF = 2'b01,
        FWD_W  = 2'b10
    } fwd_sel_e;

    function automatic logic ctrl_reg_wr(input ctrl_t c);
        return c.reg_wr;
    endfunction

    function automatic logic [1:0] ctrl_wb_sel(input ctrl_t c);
        return c.wb_sel;
    endfunction

endpackage

// File: rtl/pipe_stage_regs_reg.sv
// pipe_reg: W-bit register, async active-high reset to RST_VAL,
// sync clear to RST_VAL (i_clr beats i_en), load on i_en.
// Ports: clk, rst, i_en, i_clr, i_d[W-1:0], o_q[W-1:0].
module pipe_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else if (i_clr) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: fetch PC, IF/ID and ID/EX registers with hazard
// controls (StallF/StallD/FlushD/FlushE), E-stage operand forwarding
// muxes (For_A/For_B) and register addresses back to the hazard unit.
// Optional perf counters stall_cnt/flush_cnt when PIPE_PERF_EN is
// defined; otherwise both ports read constant 0.
module pipe_stage_regs #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter logic [31:0]       NOP_INST = cheetah_pipe_pkg::NOP_INST
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            StallF,
    input  logic                            StallD,
    input  logic                            FlushD,
    input  logic                            FlushE,
    input  logic [1:0]                      For_A,
    input  logic [1:0]                      For_B,
    input  logic [XLEN-1:0]                 pc_next,
    input  logic [31:0]                     instF,
    input  logic [XLEN-1:0]                 rdata1D,
    input  logic [XLEN-1:0]                 rdata2D,
    input  logic [XLEN-1:0]                 immD,
    input  logic [cheetah_pipe_pkg::CTRL_W-1:0] ctrlD,
    input  logic [XLEN-1:0]                 alu_resM,
    input  logic [XLEN-1:0]                 wb_dataW,
    output logic [XLEN-1:0]                 pcF,
    output logic [XLEN-1:0]                 pcD,
    output logic [31:0]                     instD,
    output logic [4:0]                      raddr1,
    output logic [4:0]                      raddr2,
    output logic [XLEN-1:0]                 pcE,
    output logic [XLEN-1:0]                 immE,
    output logic [cheetah_pipe_pkg::CTRL_W-1:0] ctrlE,
    output logic                            reg_wrE,
    output logic [1:0]                      wb_selE,
    output logic [4:0]                      raddr1E,
    output logic [4:0]                      raddr2E,
    output logic [4:0]                      waddrE,
    output logic [XLEN-1:0]                 opAE,
    output logic [XLEN-1:0]                 opBE,
    output logic [31:0]                     stall_cnt,
    output logic [31:0]                     flush_cnt
);

    import cheetah_pipe_pkg::*;

    localparam int DW = XLEN + 32;
    localparam int EW = 4 * XLEN + CTRL_W + 15;

    // ---------------- F ----------------
    // A flush means a redirect; the target must load even under stall.
    logic w_f_en;
    assign w_f_en = !StallF || FlushD;

    pipe_reg #(
        .W       (XLEN),
        .RST_VAL (RESET_PC)
    ) u_f_reg (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_f_en),
        .i_clr (1'b0),
        .i_d   (pc_next),
        .o_q   (pcF)
    );

    // ---------------- D ----------------
    logic [DW-1:0] w_d_d;
    logic [DW-1:0] w_d_q;

    assign w_d_d = {pcF, instF};

    pipe_reg #(
        .W       (DW),
        .RST_VAL ({{XLEN{1'b0}}, NOP_INST})
    ) u_d_reg (
        .clk   (clk),
        .rst   (rst),
        .i_en  (!StallD),
        .i_clr (FlushD),
        .i_d   (w_d_d),
        .o_q   (w_d_q)
    );

    assign pcD    = w_d_q[DW-1:32];
    assign instD  = w_d_q[31:0];
    assign raddr1 = instD[19:15];
    assign raddr2 = instD[24:20];

    // ---------------- E ----------------
    logic [EW-1:0]   w_e_d;
    logic [EW-1:0]   w_e_q;
    logic [XLEN-1:0] w_rdata1E;
    logic [XLEN-1:0] w_rdata2E;

    assign w_e_d = {pcD, rdata1D, rdata2D, immD, ctrlD,
                    raddr1, raddr2, instD[11:7]};

    pipe_reg #(
        .W       (EW),
        .RST_VAL ({EW{1'b0}})
    ) u_e_reg (
        .clk   (clk),
        .rst   (rst),
        .i_en  (1'b1),
        .i_clr (FlushE),
        .i_d   (w_e_d),
        .o_q   (w_e_q)
    );

    assign {pcE, w_rdata1E, w_rdata2E, immE, ctrlE,
            raddr1E, raddr2E, waddrE} = w_e_q;

    assign reg_wrE = ctrl_reg_wr(ctrl_t'(ctrlE));
    assign wb_selE = ctrl_wb_sel(ctrl_t'(ctrlE));

    // ---------------- forwarding ----------------
    // 2'b11 is reserved and falls through to the register-file value.
    always_comb begin
        opAE = w_rdata1E;
        case (For_A)
            FWD_M:   opAE = alu_resM;
            FWD_W:   opAE = wb_dataW;
            default: opAE = w_rdata1E;
        endcase
    end

    always_comb begin
        opBE = w_rdata2E;
        case (For_B)
            FWD_M:   opBE = alu_resM;
            FWD_W:   opBE = wb_dataW;
            default: opBE = w_rdata2E;
        endcase
    end

    // ---------------- perf counters ----------------
`ifdef PIPE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallD && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (FlushE && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
